// File: rtl/fadd_sched.sv
// Two-requester round-robin scheduler in front of a shared LAT-cycle pipelined FP adder.
// Optional grant statistics are enabled with the FADD_SCHED_STATS_EN macro.
module fadd_sched #(
    parameter int N   = 32,
    parameter int LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic         req1_valid,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         req0_ready,
    output logic         req1_ready,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    input  logic [N-1:0] add_out,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    output logic [N-1:0] rsp0_data,
    output logic [N-1:0] rsp1_data,
    input  logic         drain,
    output logic         idle,
    output logic [15:0]  cnt0,
    output logic [15:0]  cnt1
);

    // ptr = 0 favours requester 0, ptr = 1 favours requester 1
    logic         ptr;
    logic         grant0;
    logic         grant1;
    logic         hs;
    // Stage 0 travels with add_a/add_b; stage LAT lines up with add_out.
    logic [LAT:0] tag_v;
    logic [LAT:0] tag_id;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && !drain) begin
            grant0 = req0_valid && (!req1_valid || !ptr);
            grant1 = req1_valid && (!req0_valid ||  ptr);
        end
    end

    assign hs         = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= 1'b0;
            add_a  <= '0;
            add_b  <= '0;
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v  <= {tag_v[LAT-1:0], hs};
            tag_id <= {tag_id[LAT-1:0], grant1};
            if (hs) begin
                ptr   <= grant0;
                add_a <= grant1 ? req1_a : req0_a;
                add_b <= grant1 ? req1_b : req0_b;
            end
        end
    end

    // Both data ports simply mirror the adder; consumers qualify with valid.
    assign rsp0_data  = add_out;
    assign rsp1_data  = add_out;
    assign rsp0_valid = tag_v[LAT] & ~tag_id[LAT];
    assign rsp1_valid = tag_v[LAT] &  tag_id[LAT];
    assign idle       = ~(|tag_v) & ~hs;

`ifdef FADD_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (grant0 && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
            if (grant1 && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
        end
    end
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_fadd_sched.sv
// Directed bench for fadd_sched: single op, contention, drain, mid-flight reset, and
// (with FADD_SCHED_STATS_EN) counter saturation. Includes a small pipelined adder model.
module tb_fadd_sched;

    localparam int N   = 32;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic [N-1:0] add_a, add_b, add_out;
    logic         rsp0_valid, rsp1_valid;
    logic [N-1:0] rsp0_data, rsp1_data;
    logic         drain;
    logic         idle;
    logic [15:0]  cnt0, cnt1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0;

    fadd_sched #(.N(N), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .add_a(add_a), .add_b(add_b), .add_out(add_out),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_data(rsp0_data), .rsp1_data(rsp1_data),
        .drain(drain), .idle(idle), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Adder model: only the operand pairs the bench issues are known.
    function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ab;
        ab = {a, b};
        case (ab)
            64'h3F800000_40000000: return 32'h40400000;
            64'h40000000_3F800000: return 32'h40400000;
            64'h3F800000_3F800000: return 32'h40000000;
            64'h40000000_40000000: return 32'h40800000;
            64'h3F000000_3F000000: return 32'h3F800000;
            default:               return 32'h00000000;
        endcase
    endfunction

    logic [31:0] pipe [LAT] = '{default: 32'h0};
    always @(posedge clk) begin
        pipe[0] <= fadd_model(add_a, add_b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign add_out = pipe[LAT-1];

    // Event recorder, sampled mid-cycle
    int          hs_cyc[$];
    bit          hs_id[$];
    int          rsp_cyc[$];
    bit          rsp_id[$];
    logic [31:0] rsp_dat[$];
    bit          ready_in_drain = 1'b0;

    always @(negedge clk) begin
        if (req0_valid && req0_ready) begin hs_cyc.push_back(cyc); hs_id.push_back(1'b0); end
        if (req1_valid && req1_ready) begin hs_cyc.push_back(cyc); hs_id.push_back(1'b1); end
        if (rsp0_valid) begin rsp_cyc.push_back(cyc); rsp_id.push_back(1'b0); rsp_dat.push_back(rsp0_data); end
        if (rsp1_valid) begin rsp_cyc.push_back(cyc); rsp_id.push_back(1'b1); rsp_dat.push_back(rsp1_data); end
        if (drain && (req0_ready || req1_ready)) ready_in_drain = 1'b1;
    end

    task automatic clear_log();
        hs_cyc.delete(); hs_id.delete();
        rsp_cyc.delete(); rsp_id.delete(); rsp_dat.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n;
        rst = 1'b1; drain = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'h3F800000; req0_b = 32'h40000000;
        req1_a = 32'h40000000; req1_b = 32'h40000000;

        // Reset state with both requesters asking
        step(); step();
        chk("rst_ready0", {31'b0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'b0, req1_ready}, 32'd0);
        chk("rst_idle",   {31'b0, idle},       32'd1);
        chk("rst_add_a",  add_a,               32'h0);
        chk("rst_add_b",  add_b,               32'h0);
        chk("rst_cnt0",   {16'b0, cnt0},       32'd0);
        chk("rst_cnt1",   {16'b0, cnt1},       32'd0);
        chk("rst_rsp0",   {31'b0, rsp0_valid}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Single request: 1.0 + 2.0 on requester 0
        clear_log();
        req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
        #1;
        chk("single_ready0", {31'b0, req0_ready}, 32'd1);
        chk("single_ready1", {31'b0, req1_ready}, 32'd0);
        chk("single_idle_hs", {31'b0, idle}, 32'd0);
        t0 = cyc;
        step();
        req0_valid = 1'b0;
        chk("single_add_a", add_a, 32'h3F800000);
        chk("single_add_b", add_b, 32'h40000000);
        repeat (8) step();
        n = rsp_cyc.size();
        chk("single_rsp_count", 32'(n), 32'd1);
        for (int i = 0; i < n; i++) begin
            chk("single_rsp_id",  {31'b0, rsp_id[i]}, 32'd0);
            chk("single_rsp_lat", 32'(rsp_cyc[i] - t0), 32'd5);
            chk("single_rsp_dat", rsp_dat[i], 32'h40400000);
        end
        chk("single_idle_after", {31'b0, idle}, 32'd1);

        // Contention from reset: both valid for 6 cycles
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_log();
        req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h3F800000;
        req1_valid = 1'b1; req1_a = 32'h40000000; req1_b = 32'h40000000;
        t0 = cyc;
        repeat (6) step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (10) step();
        n = hs_cyc.size();
        chk("cont_hs_count", 32'(n), 32'd6);
        for (int i = 0; i < n; i++) begin
            chk("cont_grant_id",  {31'b0, hs_id[i]}, 32'(i % 2));
            chk("cont_grant_cyc", 32'(hs_cyc[i] - t0), 32'(i));
        end
        n = rsp_cyc.size();
        chk("cont_rsp_count", 32'(n), 32'd6);
        for (int i = 0; i < n; i++) begin
            chk("cont_rsp_id",  {31'b0, rsp_id[i]}, 32'(i % 2));
            chk("cont_rsp_cyc", 32'(rsp_cyc[i] - t0), 32'(5 + i));
            chk("cont_rsp_dat", rsp_dat[i], (i % 2 == 1) ? 32'h40800000 : 32'h40000000);
        end
`ifdef FADD_SCHED_STATS_EN
        chk("cont_cnt0", {16'b0, cnt0}, 32'd3);
        chk("cont_cnt1", {16'b0, cnt1}, 32'd3);
`else
        chk("cont_cnt0", {16'b0, cnt0}, 32'd0);
        chk("cont_cnt1", {16'b0, cnt1}, 32'd0);
`endif

        // Drain with three ops in flight
        clear_log();
        ready_in_drain = 1'b0;
        req1_valid = 1'b1; req1_a = 32'h3F000000; req1_b = 32'h3F000000;
        t0 = cyc;
        repeat (3) step();
        drain = 1'b1;
        req0_valid = 1'b1;
        #1;
        chk("drain_ready0", {31'b0, req0_ready}, 32'd0);
        chk("drain_ready1", {31'b0, req1_ready}, 32'd0);
        repeat (4) step();
        chk("drain_last_pulse", {31'b0, rsp1_valid}, 32'd1);
        chk("drain_idle_last",  {31'b0, idle},       32'd0);
        step();
        chk("drain_idle_after", {31'b0, idle},       32'd1);
        chk("drain_no_pulse",   {31'b0, rsp1_valid}, 32'd0);
        chk("drain_any_ready",  {31'b0, ready_in_drain}, 32'd0);
        chk("drain_hs_count", 32'(hs_cyc.size()), 32'd3);
        n = rsp_cyc.size();
        chk("drain_rsp_count", 32'(n), 32'd3);
        for (int i = 0; i < n; i++) begin
            chk("drain_rsp_id",  {31'b0, rsp_id[i]}, 32'd1);
            chk("drain_rsp_cyc", 32'(rsp_cyc[i] - t0), 32'(5 + i));
            chk("drain_rsp_dat", rsp_dat[i], 32'h3F800000);
        end
        drain = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Reset two cycles after a req0 handshake (leaves pointer at requester 1)
        req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
        step();
        req0_valid = 1'b0;
        step();
        #1;
        rst = 1'b1;
        clear_log();
        #1;
        chk("midrst_idle",  {31'b0, idle},       32'd1);
        chk("midrst_add_a", add_a,               32'h0);
        step();
        rst = 1'b0;
        repeat (10) step();
        chk("midrst_rsp_count", 32'(rsp_cyc.size()), 32'd0);
        chk("midrst_idle_after", {31'b0, idle}, 32'd1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("midrst_ptr_ready0", {31'b0, req0_ready}, 32'd1);
        chk("midrst_ptr_ready1", {31'b0, req1_ready}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

`ifdef FADD_SCHED_STATS_EN
        // Counter saturation with requester 1 only
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_log();
        req1_valid = 1'b1;
        repeat (65540) step();
        req1_valid = 1'b0;
        step();
        chk("sat_cnt1", {16'b0, cnt1}, 32'h0000FFFF);
        chk("sat_cnt0", {16'b0, cnt0}, 32'd0);
        clear_log();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
